// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : PC holder and word-address initiator for instruction memory, with
//            a small instruction queue presented to decode over valid/ready.
//            Optional macro FETCH_STATS_EN adds a popped-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [29:0] imem_address,
  input  logic [31:0] imem_dword,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  localparam int                 c_ptr_w = $clog2(FQ_DEPTH);
  localparam logic [c_ptr_w:0]   c_depth = (c_ptr_w + 1)'(FQ_DEPTH);

  generate
    if ((FQ_DEPTH < 2) || ((FQ_DEPTH & (FQ_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("instr_fetch_unit: FQ_DEPTH must be a power of 2 and >= 2");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
      $error("instr_fetch_unit: RESET_PC must be word aligned");
    end
  endgenerate

  logic [31:0]        r_pc;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w:0]   r_count;
  logic [31:0]        r_q_instr [FQ_DEPTH];
  logic [31:0]        r_q_pc    [FQ_DEPTH];
  logic [31:0]        r_last_instr;
  logic [31:0]        r_last_pc;

  logic w_nonempty;
  logic w_pop;
  logic w_push;

  assign w_nonempty   = (r_count != '0);
  // Redirect masks the head so decode never consumes a stale-path instruction.
  assign instr_valid  = w_nonempty && !redirect_valid;
  assign w_pop        = instr_valid && instr_ready;
  assign w_push       = fetch_en && !redirect_valid && ((r_count < c_depth) || w_pop);
  assign imem_address = r_pc[31:2];

  // When empty, show the last consumed entry so the outputs stay stable.
  assign instr    = w_nonempty ? r_q_instr[r_rd_ptr] : r_last_instr;
  assign instr_pc = w_nonempty ? r_q_pc[r_rd_ptr]    : r_last_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= {redirect_pc[31:2], 2'b00};
    end else if (w_push) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FQ_DEPTH; i++) begin
        r_q_instr[i] <= '0;
        r_q_pc[i]    <= '0;
      end
    end else if (w_push) begin
      r_q_instr[r_wr_ptr] <= imem_dword;
      r_q_pc[r_wr_ptr]    <= r_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_instr <= '0;
      r_last_pc    <= '0;
    end else if (w_pop) begin
      r_last_instr <= r_q_instr[r_rd_ptr];
      r_last_pc    <= r_q_pc[r_rd_ptr];
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] r_fetch_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
    end else if (w_pop) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Directed self-checking bench for instr_fetch_unit (mem[i] = i).
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [29:0] imem_address;
  logic [31:0] imem_dword;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Word at address i holds the value i.
  assign imem_dword = {2'b00, imem_address};

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .FQ_DEPTH (2)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_address   (imem_address),
    .imem_dword     (imem_dword),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count    (fetch_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] e_instr, input logic [31:0] e_pc);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    check({tag, "_instr"}, instr, e_instr);
    check({tag, "_pc"}, instr_pc, e_pc);
  endtask

  initial begin
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    instr_ready    = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", instr_pc, 32'd0);
    check("rst_addr", {2'b00, imem_address}, 32'd0);
`ifdef FETCH_STATS_EN
    check("rst_cnt", fetch_count, 32'd0);
`endif

    // Fill with decode stalled: queue holds 0 and 1, pc parks at 0x8
    rst_n    = 1'b1;
    fetch_en = 1'b1;
    #1;
    check("empty_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    check_head("first", 32'd0, 32'h0);
    repeat (4) tick();
    check_head("stall", 32'd0, 32'h0);
    check("stall_addr", {2'b00, imem_address}, 32'd2);

    // Release ready: one per cycle, no gap or duplicate
    instr_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_head($sformatf("stream%0d", k), k, 4 * k);
    end
    check("stream_addr", {2'b00, imem_address}, 32'd8);

    // Redirect while full
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    check("redir_mask", {31'd0, instr_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("redir_flush", {31'd0, instr_valid}, 32'd0);
    check("redir_addr", {2'b00, imem_address}, 32'h40);
    tick();
    check_head("redir_head", 32'h40, 32'h100);
`ifdef FETCH_STATS_EN
    check("cnt_redir", fetch_count, 32'd6);
`endif

    // Build two entries, then drain with fetch disabled
    instr_ready = 1'b0;
    tick();
    fetch_en    = 1'b0;
    instr_ready = 1'b1;
    #1;
    check("drain_addr0", {2'b00, imem_address}, 32'h42);
    tick();
    check_head("drain1", 32'h41, 32'h104);
    check("drain_addr1", {2'b00, imem_address}, 32'h42);
    tick();
    check("drain_valid", {31'd0, instr_valid}, 32'd0);
    check("drain_hold", instr, 32'h41);
    check("drain_addr2", {2'b00, imem_address}, 32'h42);
`ifdef FETCH_STATS_EN
    check("cnt_drain", fetch_count, 32'd8);
`endif

    // PC wrap at top of address space; low redirect bits ignored
    fetch_en       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("wrap_addr0", {2'b00, imem_address}, 32'h3FFF_FFFF);
    tick();
    check_head("wrap_top", 32'h3FFF_FFFF, 32'hFFFF_FFFC);
    check("wrap_addr1", {2'b00, imem_address}, 32'd0);
    tick();
    check_head("wrap_zero", 32'd0, 32'd0);
    check("wrap_addr2", {2'b00, imem_address}, 32'd1);

    // Asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, instr_valid}, 32'd0);
    check("arst_addr", {2'b00, imem_address}, 32'd0);
    check("arst_instr", instr, 32'd0);
`ifdef FETCH_STATS_EN
    check("arst_cnt", fetch_count, 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    for (int t = 1; t <= 11; t++) begin
      tick();
      check_head($sformatf("restart%0d", t), t - 1, 4 * (t - 1));
    end
`ifdef FETCH_STATS_EN
    check("cnt_restart", fetch_count, 32'd10);
`endif

    // Back-to-back redirects: the last one wins
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    redirect_pc    = 32'h0000_0300;
    #1;
    check("b2b_mask", {31'd0, instr_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("b2b_addr", {2'b00, imem_address}, 32'hC0);
    tick();
    check_head("b2b_head", 32'hC0, 32'h300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
